// File: rtl/fft8_pkg.sv
// Shared types, constants and arithmetic helpers for the 8-point pipelined FFT.
// Build option: define FFT_SAT_EN to saturate every add/sub/multiply result;
// otherwise results wrap modulo 2^16.
package fft8_pkg;

  localparam int DW   = 16;
  localparam int FRAC = 8;

  // Complex sample, Q8.8 per component, packed as {re, im}
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;

  // Twiddles W^k = e^(-j*2*pi*k/8)
  localparam cplx_t W0 = {16'sh0100, 16'sh0000};
  localparam cplx_t W1 = {16'sh00B5, 16'shFF4B};
  localparam cplx_t W2 = {16'sh0000, 16'shFF00};
  localparam cplx_t W3 = {16'shFF4B, 16'shFF4B};

  function automatic cplx_t tw_sel(input int k);
    case (k)
      1:       return W1;
      2:       return W2;
      3:       return W3;
      default: return W0;
    endcase
  endfunction

  // 3-bit bit reversal used to reorder the inputs for decimation-in-time
  function automatic int bitrev3(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  // Reduce a wide signed intermediate to one 16-bit component
  function automatic logic signed [DW-1:0] fit16(input logic signed [31:0] v);
`ifdef FFT_SAT_EN
    if (v > 32'sd32767)       return 16'sh7FFF;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return v[DW-1:0];
`else
    return v[DW-1:0];
`endif
  endfunction

  // Drop the fractional bits of a Q16.16 product sum (floor)
  function automatic logic signed [31:0] shr_frac(input logic signed [32:0] acc);
    return 32'(acc >>> FRAC);
  endfunction

endpackage

// File: rtl/fft8_butterfly.sv
// Radix-2 DIT butterfly: y0 = a + b*W, y1 = a - b*W (combinational).
// Arithmetic overflow behaviour follows FFT_SAT_EN via fft8_pkg::fit16.
module fft8_butterfly
  import fft8_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  input  cplx_t tw,
  output cplx_t y0,
  output cplx_t y1
);

  cplx_t                prod;
  logic signed [31:0]   rr, ii, ri, ir;
  logic signed [32:0]   acc_re, acc_im;

  // Twiddle product, then the sum/difference pair. The twiddle is always a
  // constant at each instance, so the W0/W2 branches fold the multiplier away.
  always_comb begin
    prod   = b;
    rr     = '0;
    ii     = '0;
    ri     = '0;
    ir     = '0;
    acc_re = '0;
    acc_im = '0;
    if (tw == W0) begin
      prod = b;
    end else if (tw == W2) begin
      // b * (-j) = (b.im, -b.re)
      prod.re = b.im;
      prod.im = fit16(-32'(b.re));
    end else begin
      rr      = 32'(b.re) * 32'(tw.re);
      ii      = 32'(b.im) * 32'(tw.im);
      ri      = 32'(b.re) * 32'(tw.im);
      ir      = 32'(b.im) * 32'(tw.re);
      acc_re  = 33'(rr) - 33'(ii);
      acc_im  = 33'(ri) + 33'(ir);
      prod.re = fit16(shr_frac(acc_re));
      prod.im = fit16(shr_frac(acc_im));
    end
    y0.re = fit16(32'(a.re) + 32'(prod.re));
    y0.im = fit16(32'(a.im) + 32'(prod.im));
    y1.re = fit16(32'(a.re) - 32'(prod.re));
    y1.im = fit16(32'(a.im) - 32'(prod.im));
  end

endmodule

// File: rtl/main.sv
// 8-point radix-2 DIT FFT, three registered butterfly stages, one frame per
// cycle, latency 3. Optional saturation via FFT_SAT_EN (see fft8_pkg).
module main
  import fft8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] a2,
  input  logic [31:0] a3,
  input  logic [31:0] a4,
  input  logic [31:0] a5,
  input  logic [31:0] a6,
  input  logic [31:0] a7,
  output logic [31:0] b0,
  output logic [31:0] b1,
  output logic [31:0] b2,
  output logic [31:0] b3,
  output logic [31:0] b4,
  output logic [31:0] b5,
  output logic [31:0] b6,
  output logic [31:0] b7
);

  cplx_t x    [8];
  cplx_t y0   [8];
  cplx_t y1   [8];
  cplx_t y2   [8];
  cplx_t s_p0 [8];
  cplx_t s_p1 [8];
  cplx_t s_p2 [8];

  assign x[0] = a0;
  assign x[1] = a1;
  assign x[2] = a2;
  assign x[3] = a3;
  assign x[4] = a4;
  assign x[5] = a5;
  assign x[6] = a6;
  assign x[7] = a7;

  // Stage 1: 2-point DFTs on bit-reversed input pairs, all W0
  for (genvar i = 0; i < 4; i++) begin : g_st1
    fft8_butterfly u_bf (
      .a  (x[bitrev3(2*i)]),
      .b  (x[bitrev3(2*i+1)]),
      .tw (W0),
      .y0 (y0[2*i]),
      .y1 (y0[2*i+1])
    );
  end

  // Stage 2: 4-point combine within each half, twiddles W0 and W2
  for (genvar g = 0; g < 2; g++) begin : g_st2
    for (genvar j = 0; j < 2; j++) begin : g_bf
      fft8_butterfly u_bf (
        .a  (s_p0[4*g+j]),
        .b  (s_p0[4*g+j+2]),
        .tw (tw_sel(2*j)),
        .y0 (y1[4*g+j]),
        .y1 (y1[4*g+j+2])
      );
    end
  end

  // Stage 3: 8-point combine, twiddles W0..W3, natural-order result
  for (genvar j = 0; j < 4; j++) begin : g_st3
    fft8_butterfly u_bf (
      .a  (s_p1[j]),
      .b  (s_p1[j+4]),
      .tw (tw_sel(j)),
      .y0 (y2[j]),
      .y1 (y2[j+4])
    );
  end

  // Stage registers; reset clears every frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        s_p0[i] <= '0;
        s_p1[i] <= '0;
        s_p2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        s_p0[i] <= y0[i];
        s_p1[i] <= y1[i];
        s_p2[i] <= y2[i];
      end
    end
  end

  assign b0 = s_p2[0];
  assign b1 = s_p2[1];
  assign b2 = s_p2[2];
  assign b3 = s_p2[3];
  assign b4 = s_p2[4];
  assign b5 = s_p2[5];
  assign b6 = s_p2[6];
  assign b7 = s_p2[7];

endmodule

// File: tb/tb_main.sv
// Directed self-checking bench for the 8-point FFT top "main".
// Honors FFT_SAT_EN for the overflow vector.
module tb_main;

  logic        clk;
  logic        rst_n;
  logic [31:0] a  [8];
  logic [31:0] bw [8];

  int n_cmp;
  int n_err;

  logic [31:0] fr [7][8];
  logic [31:0] ex [7][8];
  int          seq [6];

  main dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a0 (a[0]), .a1 (a[1]), .a2 (a[2]), .a3 (a[3]),
    .a4 (a[4]), .a5 (a[5]), .a6 (a[6]), .a7 (a[7]),
    .b0 (bw[0]), .b1 (bw[1]), .b2 (bw[2]), .b3 (bw[3]),
    .b4 (bw[4]), .b5 (bw[5]), .b6 (bw[6]), .b7 (bw[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic apply(input int f);
    for (int i = 0; i < 8; i++) a[i] = fr[f][i];
  endtask

  task automatic check_frame(input int f, input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_b%0d", tag, i), bw[i], ex[f][i]);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_b%0d", tag, i), bw[i], 32'h0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;

    // 0: all ones (1.0)
    fr[0] = '{32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000,
              32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000};
    ex[0] = '{32'h08000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    // 1: impulse at x[0]
    fr[1] = '{32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    ex[1] = '{32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000,
              32'h01000000, 32'h01000000, 32'h01000000, 32'h01000000};
    // 2: impulse at x[1] -> W^k
    fr[2] = '{32'h0, 32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    ex[2] = '{32'h01000000, 32'h00B5FF4B, 32'h0000FF00, 32'hFF4BFF4B,
              32'hFF000000, 32'hFF4B00B5, 32'h00000100, 32'h00B500B5};
    // 3: alternating +1/-1
    fr[3] = '{32'h01000000, 32'hFF000000, 32'h01000000, 32'hFF000000,
              32'h01000000, 32'hFF000000, 32'h01000000, 32'hFF000000};
    ex[3] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h08000000, 32'h0, 32'h0, 32'h0};
    // 4: full-scale DC, overflows in every stage
    fr[4] = '{32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000,
              32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000};
`ifdef FFT_SAT_EN
    ex[4] = '{32'h7FFF0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`else
    ex[4] = '{32'hFFF80000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
`endif
    // 5: one LSB at x[1]; twiddle products truncate toward minus infinity
    fr[5] = '{32'h0, 32'h00010000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    ex[5] = '{32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFFFFFF,
              32'hFFFF0000, 32'h00000001, 32'h00000001, 32'h00010001};
    // 6: pure imaginary j at x[1] -> j*W^k
    fr[6] = '{32'h0, 32'h00000100, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    ex[6] = '{32'h00000100, 32'h00B500B5, 32'h01000000, 32'h00B5FF4B,
              32'h0000FF00, 32'hFF4BFF4B, 32'hFF000000, 32'hFF4B00B5};

    seq = '{0, 1, 2, 3, 5, 6};

    // Reset state
    rst_n = 1'b0;
    apply(0);
    #1;
    check_zero("reset");
    @(posedge clk); #1;
    check_zero("reset_clk");
    rst_n = 1'b1;

    // Single frames held stable, checked after 3 edges
    for (int f = 0; f < 7; f++) begin
      apply(f);
      repeat (3) @(posedge clk);
      #1;
      check_frame(f, $sformatf("frame%0d", f));
    end

    // Back-to-back frames, one per cycle
    for (int k = 0; k < 9; k++) begin
      if (k >= 3) check_frame(seq[k-3], $sformatf("b2b%0d", k-3));
      if (k < 6) apply(seq[k]);
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-stream
    apply(0);
    repeat (3) @(posedge clk);
    #1;
    check_frame(0, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    apply(2);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("post_rst_lat2");
    @(posedge clk); #1;
    check_frame(2, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
